// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_n register file: clear-sequencer state
// encoding, default geometry and an address range helper.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // True when addr names a real entry; matters only for non-power-of-2 depths.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer for regfile_n. On clr_req while idle it walks a pointer over
// every entry, one per cycle, asking the array to write zero at clr_addr.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    clr_state_t        state_reg;
    clr_state_t        state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] ptr_next;

    // Next-state logic: clr_req is only looked at in idle, so a clear can never restart.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    ptr_next   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_reg == LAST_PTR) begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // State and pointer registers; reset abandons any clear in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // busy is a straight decode of the state register, so it is glitch-free.
    assign busy     = (state_reg == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr_reg;

endmodule

// File: rtl/regfile_n.sv
// regfile_n: one write port, two combinational read ports with write-to-read
// forwarding, and a built-in sequencer that zeroes the file one entry per cycle.
// Optional build macro ZERO_REG_EN makes entry 0 read as a constant zero and
// drops writes to it.
module regfile_n
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              clr_req,
    output logic              busy
);

    logic [WIDTH-1:0]  entry_reg [DEPTH];
    logic [DEPTH-1:0]  entry_we;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              ext_we;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;

    regfile_clr_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A write from outside lands only when idle and aimed at a real, writable entry.
    // The same qualifier gates forwarding, so a dropped write is never forwarded.
    always_comb begin
        ext_we = wr_en && !busy && addr_in_range(32'(wr_addr), DEPTH);
`ifdef ZERO_REG_EN
        if (wr_addr == '0) begin
            ext_we = 1'b0;
        end
`endif
    end

    // While clearing, the sequencer owns the write port and always writes zero.
    assign sel_we   = busy ? clr_we   : ext_we;
    assign sel_addr = busy ? clr_addr : wr_addr;
    assign sel_data = busy ? '0       : wr_data;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = sel_we && (sel_addr == ADDR_W'(gi));
        end
    endgenerate

    // Storage: per-entry enabled registers. Under ZERO_REG_EN entry 0 is only ever
    // written with zero (by the clear walk), so it stays zero from reset onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    entry_reg[i] <= sel_data;
                end
            end
        end
    end

    // Read port A: array lookup (out-of-range reads zero), then same-cycle forwarding.
    always_comb begin
        rd_data_a = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_data_a = entry_reg[i];
            end
        end
        if (ext_we && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
`ifdef ZERO_REG_EN
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end
`endif
    end

    // Read port B: identical to port A, forwarding decided independently.
    always_comb begin
        rd_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_data_b = entry_reg[i];
            end
        end
        if (ext_we && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
`ifdef ZERO_REG_EN
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end
`endif
    end

endmodule

// File: doc/regfile_n.md
Name: regfile_n

Overview:
Parametrised multi-entry register file for the datapath, built from per-entry write-enabled registers.
- 1 write port, 2 combinational read ports with write-to-read forwarding.
- Built-in clear sequencer that zeroes every entry one per cycle on request.
- Sits between the decode stage (addresses) and the adder/ALU operand inputs.

Parameters:
WIDTH, 32, bits per entry
DEPTH, 32, number of entries (>=2)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
wr_en  input  1  write request this cycle
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_addr_a  input  ADDR_W  read port A address
rd_data_a  output  WIDTH  read port A data (combinational)
rd_addr_b  input  ADDR_W  read port B address
rd_data_b  output  WIDTH  read port B data (combinational)
clr_req  input  1  start clear sequence (sampled when idle)
busy  output  1  clear sequence in progress

Behaviour:
- Reset (reset=0, async): all entries=0, FSM=IDLE, clear pointer=0, busy=0; rd_data_* reflect zeroed contents immediately.
- Write: in IDLE with wr_en=1, entry[wr_addr] takes wr_data at the rising edge; 1-cycle latency. wr_addr>=DEPTH (non-power-of-2 DEPTH): write dropped.
- Read: rd_data_x = entry[rd_addr_x], combinational; rd_addr_x>=DEPTH returns 0.
- Forwarding: in IDLE, if wr_en=1 and rd_addr_x==wr_addr (valid address), rd_data_x=wr_data in the same cycle. Applies independently to both ports.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, ptr=0.
  - CLEAR: each edge writes 0 to entry[ptr] and increments ptr. When ptr==DEPTH-1, that entry is written and FSM -> IDLE, ptr=0.
  - Clear takes exactly DEPTH cycles in CLEAR.
- busy=1 iff FSM==CLEAR (registered; rises the cycle after clr_req is sampled).
- During CLEAR:
  - wr_en ignored; no write, no forwarding.
  - Reads return current array contents: entries below ptr already 0, the rest unchanged.
  - clr_req ignored, no restart.
- Simultaneous wr_en and clr_req in IDLE: the write is performed on that edge, and CLEAR starts on the same edge (the written entry is zeroed later).
- Reset asserted mid-clear: immediate return to reset state; the sequence is not resumed.
- clr_req held high continuously: a new CLEAR begins on the edge after returning to IDLE.

Optional Feature:
ZERO_REG_EN
- Defined:
  - Entry 0 is hardwired to 0.
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including when forwarding would apply.
  - The clear sequence still visits entry 0, with no effect.
- Undefined: entry 0 is an ordinary storage entry.

Decomposition:
- Package regfile_pkg:
  - FSM state enum (ST_IDLE, ST_CLEAR).
  - Default WIDTH/DEPTH constants.
  - Helper function for address-in-range check.
- Sub-module regfile_clr_fsm: owns the state, ptr counter and busy; outputs clr_we and clr_addr to the array write mux.
- Top level holds the storage array, write mux (external vs clear), read muxes and forwarding.

Test Plan:
- Reset then read addr 5 on A, addr 31 on B -> both 0; write 0xDEADBEEF to addr 5 -> next cycle rd_data_a=0xDEADBEEF.
- wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr_a=rd_addr_b=7 in the same cycle -> both ports show 0x12345678 before the edge (forwarding).
- Fill all 32 entries with address-based values, pulse clr_req -> busy high for exactly 32 cycles. Mid-clear, read addr 3 =0 and addr 30 = its old value. wr_en during busy is dropped: post-clear all entries are 0.
- Pulse reset low during cycle 10 of the clear -> busy=0 immediately, all entries 0; clr_req issued afterwards runs a full 32-cycle clear.
- Issue wr_en (addr 9, 0xA5A5A5A5) and clr_req together -> entry 9 reads 0xA5A5A5A5 during the first clear cycles, reads 0 after the clear completes.
- With ZERO_REG_EN: write 0xFFFFFFFF to addr 0 -> rd_data_a(addr 0)=0 both same-cycle and next cycle. Without ZERO_REG_EN: the same write reads back 0xFFFFFFFF next cycle.
